// File: rtl/interp_sequencer_pkg.sv
// Shared types and constants for the 8x8 HEVC sub-pixel interpolation sequencer.
package interp_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_HPASS = 3'd2,
        S_DRAIN = 3'd3,
        S_VPASS = 3'd4,
        S_FLUSH = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam int NUM_PIXEL_DEF = 8;
    localparam int TAPS_DEF      = 8;
    localparam int ROWS          = NUM_PIXEL_DEF + TAPS_DEF - 1;

    localparam int SEL_W   = 8;
    localparam int PLANE_W = 2;
    localparam int ROW_W   = 3;

    localparam logic [PLANE_W-1:0] PLANE_INT = 2'd0;
    localparam logic [PLANE_W-1:0] PLANE_A   = 2'd1;
    localparam logic [PLANE_W-1:0] PLANE_B   = 2'd2;
    localparam logic [PLANE_W-1:0] PLANE_C   = 2'd3;

    // Vertical-pass mux select: the sub-pixel planes follow the integer rows.
    function automatic logic [SEL_W-1:0] vsel(input int                 rows,
                                              input int                 num_pixel,
                                              input logic [PLANE_W-1:0] plane,
                                              input logic [ROW_W-1:0]   row);
        return SEL_W'(rows + num_pixel * int'(plane) + int'(row));
    endfunction

endpackage

// File: rtl/interp_sequencer_if.sv
// Control/handshake bundle between the interpolation sequencer and its datapath/host.
interface interp_sequencer_if;
    import interp_pkg::*;

    logic               start;
    logic               busy;
    logic               done;
    logic               in_valid;
    logic               in_ready;
    logic [SEL_W-1:0]   sel;
    logic               fir_en;
    logic               sr_load_L;
    logic               out_valid;
    logic               out_ready;
    logic [PLANE_W-1:0] out_plane;
    logic [ROW_W-1:0]   out_row;

    modport master (
        output start, in_valid, out_ready,
        input  busy, done, in_ready, sel, fir_en, sr_load_L,
               out_valid, out_plane, out_row
    );

    modport slave (
        input  start, in_valid, out_ready,
        output busy, done, in_ready, sel, fir_en, sr_load_L,
               out_valid, out_plane, out_row
    );

endinterface

// File: rtl/interp_sequencer_out_stage.sv
// One-deep output register tagging each vertical-pass row with its plane and row index.
module interp_out_stage
    import interp_pkg::*;
(
    input  logic               clock,
    input  logic               reset_L,
    input  logic               issue,
    input  logic [PLANE_W-1:0] issue_plane,
    input  logic [ROW_W-1:0]   issue_row,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [PLANE_W-1:0] out_plane,
    output logic [ROW_W-1:0]   out_row
);

    // A new issue overwrites the slot in the same cycle the old row hands off.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            out_valid <= 1'b0;
            out_plane <= PLANE_INT;
            out_row   <= '0;
        end else if (issue) begin
            out_valid <= 1'b1;
            out_plane <= issue_plane;
            out_row   <= issue_row;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/interp_sequencer.sv
// Control FSM for the 8x8 interpolation datapath: horizontal pass, then 32-row vertical pass.
module interp_sequencer
    import interp_pkg::*;
#(
    parameter int NUM_PIXEL = NUM_PIXEL_DEF,
    parameter int TAPS      = TAPS_DEF
) (
    input  logic              clock,
    input  logic              reset_L,
    interp_sequencer_if.slave sif
);

    localparam int               NROWS      = NUM_PIXEL + TAPS - 1;
    localparam logic [SEL_W-1:0] SEL_H_LAST = SEL_W'(NROWS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(NUM_PIXEL - 1);

    if ((NROWS + 4 * NUM_PIXEL - 1 > (1 << SEL_W) - 1) || (NUM_PIXEL > (1 << ROW_W))) begin : g_range_check
        $error("interp_sequencer: NUM_PIXEL/TAPS exceed select or row width");
    end

    state_t             state;
    logic [SEL_W-1:0]   sel_q;
    logic [PLANE_W-1:0] plane_q;
    logic [ROW_W-1:0]   row_q;
    logic               busy_q;
    logic               done_q;
    logic               in_ready_q;
    logic               hfir_q;
    logic               sr_load_L_q;

    logic               issue;
    logic               last_row;
    logic [PLANE_W-1:0] plane_nx;
    logic [ROW_W-1:0]   row_nx;

    // A row issues whenever the output slot is empty or being emptied this cycle.
    always_comb begin
        issue    = (state == S_VPASS) && (!sif.out_valid || sif.out_ready);
        last_row = (row_q == ROW_LAST);
        plane_nx = plane_q;
        row_nx   = row_q + ROW_W'(1);
        if (last_row) begin
            plane_nx = plane_q + PLANE_W'(1);
            row_nx   = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state       <= S_IDLE;
            sel_q       <= '0;
            plane_q     <= PLANE_INT;
            row_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            hfir_q      <= 1'b0;
            sr_load_L_q <= 1'b1;
        end else begin
            done_q      <= 1'b0;
            // Shift registers load one cycle behind each horizontal-pass row.
            sr_load_L_q <= (state != S_HPASS);
            case (state)
                S_IDLE: begin
                    if (sif.start) begin
                        state      <= S_LOAD;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (sif.in_valid) begin
                        state      <= S_HPASS;
                        in_ready_q <= 1'b0;
                        hfir_q     <= 1'b1;
                        sel_q      <= '0;
                    end
                end
                S_HPASS: begin
                    if (sel_q == SEL_H_LAST) begin
                        state <= S_DRAIN;
                    end else begin
                        sel_q <= sel_q + SEL_W'(1);
                    end
                end
                S_DRAIN: begin
                    state   <= S_VPASS;
                    hfir_q  <= 1'b0;
                    plane_q <= PLANE_INT;
                    row_q   <= '0;
                    sel_q   <= vsel(NROWS, NUM_PIXEL, PLANE_INT, '0);
                end
                S_VPASS: begin
                    if (issue) begin
                        if (plane_q == PLANE_C && last_row) begin
                            state <= S_FLUSH;
                        end else begin
                            plane_q <= plane_nx;
                            row_q   <= row_nx;
                            sel_q   <= vsel(NROWS, NUM_PIXEL, plane_nx, row_nx);
                        end
                    end
                end
                S_FLUSH: begin
                    if (sif.out_valid && sif.out_ready) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state      <= S_IDLE;
                    busy_q     <= 1'b0;
                    in_ready_q <= 1'b0;
                    hfir_q     <= 1'b0;
                end
            endcase
        end
    end

    interp_out_stage u_out_stage (
        .clock       (clock),
        .reset_L     (reset_L),
        .issue       (issue),
        .issue_plane (plane_q),
        .issue_row   (row_q),
        .out_ready   (sif.out_ready),
        .out_valid   (sif.out_valid),
        .out_plane   (sif.out_plane),
        .out_row     (sif.out_row)
    );

    assign sif.busy      = busy_q;
    assign sif.done      = done_q;
    assign sif.in_ready  = in_ready_q;
    assign sif.sel       = sel_q;
    assign sif.fir_en    = hfir_q | issue;
    assign sif.sr_load_L = sr_load_L_q;

endmodule

// File: tb/tb_interp_sequencer.sv
// Scoreboard bench for interp_sequencer: a handshake-level model predicts row delivery and done timing.
module tb_interp_sequencer;
    import interp_pkg::*;

    localparam int MAXC = 8192;
    localparam int NP   = 8;
    localparam int NOUT = 4 * NP;

    typedef struct {
        int plane;
        int row;
        int cyc;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_L = 1'b1;
    int   cyc         = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    bit   rdy [MAXC];
    bit   st  [MAXC];
    bit   iv  [MAXC];

    exp_t exp_q[$];
    int   exp_done[$];

    interp_sequencer_if sif();

    interp_sequencer #(.NUM_PIXEL(NP), .TAPS(8)) dut (
        .clock   (clock),
        .reset_L (reset_L),
        .sif     (sif)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Row k issues once the slot frees; it is accepted on the first ready cycle after it appears.
    function automatic int model_block(input int s, input int w);
        int   c;
        int   a;
        exp_t e;
        c = s + 1 + w + ROWS + 2;
        a = c;
        for (int k = 0; k < NOUT; k++) begin
            a = c + 1;
            while (a < MAXC - 1 && !rdy[a]) a++;
            e.plane = k / NP;
            e.row   = k % NP;
            e.cyc   = a;
            exp_q.push_back(e);
            c = a;
        end
        exp_done.push_back(a + 1);
        return a + 1;
    endfunction

    task automatic launch(input int w, output int s, output int d);
        s = cyc + 2;
        st[s] = 1'b1;
        for (int c = s + 1; c <= s + w; c++) iv[c] = 1'b0;
        d = model_block(s, w);
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_done.size() != 0) && n < budget) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk({nm, "_outstanding"}, exp_q.size() + exp_done.size(), 0);
        exp_q.delete();
        exp_done.delete();
        repeat (2) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic chk_reset_values(input string nm);
        chk({nm, "_sel"},       sif.sel,       0);
        chk({nm, "_out_plane"}, sif.out_plane, 0);
        chk({nm, "_out_row"},   sif.out_row,   0);
        chk({nm, "_busy"},      sif.busy,      0);
        chk({nm, "_done"},      sif.done,      0);
        chk({nm, "_in_ready"},  sif.in_ready,  0);
        chk({nm, "_fir_en"},    sif.fir_en,    0);
        chk({nm, "_out_valid"}, sif.out_valid, 0);
        chk({nm, "_sr_load_L"}, sif.sr_load_L, 1);
    endtask

    // Driver: inputs change 1 time unit after each rising edge from per-cycle tables.
    initial begin
        sif.start     = 1'b0;
        sif.in_valid  = 1'b1;
        sif.out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (cyc < MAXC) begin
                sif.start     = st[cyc];
                sif.in_valid  = iv[cyc];
                sif.out_ready = rdy[cyc];
            end
        end
    end

    // Monitor: pops the scoreboard on every output handshake and done pulse.
    initial begin
        exp_t e;
        int   ed;
        forever begin
            @(negedge clock);
            if (reset_L === 1'b1) begin
                if (sif.out_valid === 1'b1 && sif.out_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_row: plane %0d row %0d at cycle %0d, expected no row", sif.out_plane, sif.out_row, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("row_plane", sif.out_plane, e.plane);
                        chk("row_index", sif.out_row,   e.row);
                        chk("row_cycle", cyc,           e.cyc);
                    end
                end
                if (sif.done !== 1'b0) begin
                    if (exp_done.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_done: done=%0d at cycle %0d, expected 0", sif.done, cyc);
                    end else begin
                        ed = exp_done.pop_front();
                        chk("done_cycle", cyc, ed);
                    end
                end
            end
        end
    end

    initial begin
        int s, d, s2, d2, w, lowcnt, first, last, npulse;
        for (int i = 0; i < MAXC; i++) begin
            rdy[i] = 1'b1;
            iv[i]  = 1'b1;
            st[i]  = 1'b0;
        end

        // Asynchronous reset
        #2 reset_L = 1'b0;
        #1 chk_reset_values("reset");
        repeat (3) @(negedge clock);
        reset_L = 1'b1;
        @(negedge clock);
        #1;

        // Nominal block, no stalls
        launch(0, s, d);
        lowcnt = 0;
        first  = -1;
        last   = -1;
        for (int r = 1; r <= 52; r++) begin
            goto_cycle(s + r);
            if (r == 1) chk("load_in_ready", sif.in_ready, 1);
            if (r >= 2 && r <= 16) begin
                chk("hpass_sel",    sif.sel,    r - 2);
                chk("hpass_fir_en", sif.fir_en, 1);
            end
            if (r == 17) begin
                chk("drain_sel",    sif.sel,    14);
                chk("drain_fir_en", sif.fir_en, 1);
            end
            if (r >= 18 && r <= 49) chk("vpass_sel", sif.sel, r - 3);
            if (r == 51) chk("done_busy", sif.busy, 0);
            if (sif.sr_load_L === 1'b0) begin
                if (first < 0) first = r;
                last = r;
                lowcnt++;
            end
        end
        chk("sr_load_low_cycles", lowcnt, ROWS);
        chk("sr_load_first_low",  first,  3);
        chk("sr_load_last_low",   last,   17);
        wait_drain("nominal", 200);

        // in_valid held low for 10 cycles in LOAD
        launch(10, s, d);
        for (int r = 1; r <= 11; r++) begin
            goto_cycle(s + r);
            chk("load_wait_in_ready", sif.in_ready, 1);
            chk("load_wait_fir_en",   sif.fir_en,   0);
        end
        goto_cycle(s + 12);
        chk("load_wait_hpass_sel",    sif.sel,    0);
        chk("load_wait_hpass_fir_en", sif.fir_en, 1);
        chk("load_wait_in_ready_off", sif.in_ready, 0);
        wait_drain("load_wait", 200);

        // out_ready low for 5 cycles while plane 1 row 3 is presented
        s = cyc + 2;
        for (int c = s + 30; c <= s + 34; c++) rdy[c] = 1'b0;
        launch(0, s, d);
        for (int r = 30; r <= 34; r++) begin
            goto_cycle(s + r);
            chk("stall_out_valid", sif.out_valid, 1);
            chk("stall_out_plane", sif.out_plane, 1);
            chk("stall_out_row",   sif.out_row,   3);
            chk("stall_sel",       sif.sel,       27);
            chk("stall_fir_en",    sif.fir_en,    0);
        end
        goto_cycle(s + 35);
        chk("stall_release_fir_en", sif.fir_en, 1);
        wait_drain("stall", 200);

        // start while busy and during DONE is ignored
        launch(0, s, d);
        st[s + 10] = 1'b1;
        st[s + 30] = 1'b1;
        st[d]      = 1'b1;
        wait_drain("start_busy", 200);
        goto_cycle(d + 5);
        chk("start_done_ignored_busy",     sif.busy,     0);
        chk("start_done_ignored_in_ready", sif.in_ready, 0);
        goto_cycle(d + 60);

        // Back-to-back blocks with start held high
        s = cyc + 2;
        for (int c = s; c <= s + 52; c++) st[c] = 1'b1;
        d  = model_block(s, 0);
        s2 = s + 52;
        d2 = model_block(s2, 0);
        goto_cycle(s + 53);
        chk("b2b_load_in_ready", sif.in_ready, 1);
        chk("b2b_load_busy",     sif.busy,     1);
        wait_drain("b2b", 300);
        goto_cycle(d2 + 3);

        // Reset in VPASS at sel=30 aborts without a done pulse
        launch(0, s, d);
        goto_cycle(s + 33);
        chk("abort_pre_sel", sif.sel, 30);
        #2 reset_L = 1'b0;
        #1 chk_reset_values("abort");
        exp_q.delete();
        exp_done.delete();
        @(negedge clock);
        reset_L = 1'b1;
        #1;
        goto_cycle(cyc + 60);
        chk("abort_idle_busy", sif.busy, 0);

        // Randomized load waits, backpressure and stray starts
        for (int t = 0; t < 8; t++) begin
            s = cyc + 2;
            w = $urandom_range(0, 8);
            for (int c = s; c < s + 400 && c < MAXC; c++) rdy[c] = ($urandom_range(0, 9) < 7);
            launch(w, s, d);
            npulse = $urandom_range(0, 3);
            for (int p = 0; p < npulse; p++) st[$urandom_range(s + 1, d)] = 1'b1;
            wait_drain("random", 600);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
